// File: rtl/pipe_ctrl.sv
// Y86-64 five-stage pipeline control: hazard detection, stall/bubble generation and exception-drain FSM.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int         CNT_W   = 32,
  parameter logic [3:0] I_RET   = 4'h9,
  parameter logic [3:0] I_JXX   = 4'h7,
  parameter logic [3:0] I_MRMOV = 4'h5,
  parameter logic [3:0] I_POP   = 4'hB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_cnd,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc_en,
  output logic [3:0]       cpu_stat,
  output logic             halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    STOP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic lu, ret, mp, exm, exw;

  // Hazard terms are pure functions of the current stage contents.
  assign lu  = ((E_icode == I_MRMOV) || (E_icode == I_POP)) && (E_dstM != REG_NONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mp  = (E_icode == I_JXX) && !e_cnd;
  assign exm = (m_stat != STAT_AOK);
  assign exw = (W_stat != STAT_AOK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (exw) begin
          state_nxt = STOP;
        end else if (exm) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (exw) begin
          state_nxt = STOP;
        end
      end
      STOP:    state_nxt = STOP;
      default: state_nxt = RUN;
    endcase
  end

  // Reset overrides everything so every stage register is flushed while rst is held.
  always_comb begin
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    W_stall   = 1'b0;
    set_cc_en = 1'b0;
    if (rst) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          F_stall   = lu || ret;
          D_stall   = lu;
          D_bubble  = mp || (!lu && ret);
          E_bubble  = mp || lu;
          M_bubble  = exm || exw;
          W_stall   = exw;
          set_cc_en = !exm && !exw;
        end
        DRAIN: begin
          F_stall   = 1'b1;
          D_stall   = lu;
          D_bubble  = mp || (!lu && ret);
          E_bubble  = mp || lu;
          M_bubble  = 1'b1;
          W_stall   = exw;
          set_cc_en = 1'b0;
        end
        STOP: begin
          F_stall   = 1'b1;
          D_stall   = 1'b1;
          E_bubble  = 1'b1;
          M_bubble  = 1'b1;
          W_stall   = 1'b1;
        end
        default: begin
          D_bubble = 1'b1;
          E_bubble = 1'b1;
          M_bubble = 1'b1;
        end
      endcase
    end
  end

  // The architected status is captured from W exactly once, on the edge that enters STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_stat <= STAT_AOK;
      halted   <= 1'b0;
    end else if ((state != STOP) && (state_nxt == STOP)) begin
      cpu_stat <= W_stat;
      halted   <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != STOP) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
      if ((state == RUN) && lu) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if ((state == RUN) && mp) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model queues expected outputs, a monitor compares them.
// Counter checks are enabled when PIPE_PERF_CNT_EN is defined.
module tb_pipe_ctrl;

  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] D_icode = 4'h1, E_icode = 4'h1, M_icode = 4'h1;
  logic [3:0] E_dstM = 4'hF, d_srcA = 4'hF, d_srcB = 4'hF;
  logic       e_cnd = 1'b1;
  logic [3:0] m_stat = 4'h1, W_stat = 4'h1;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en;
  logic [3:0] cpu_stat;
  logic       halted;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;
`endif

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .e_cnd(e_cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc_en(set_cc_en), .cpu_stat(cpu_stat), .halted(halted)
`ifdef PIPE_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]       ctrl;
    logic [3:0]       stat;
    logic             halt;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] stl;
    logic [CNT_W-1:0] fls;
    string            tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: mode 0 = running, 1 = draining, 2 = stopped.
  int               mdl_mode = 0;
  logic [3:0]       mdl_stat = 4'h1;
  logic [CNT_W-1:0] mdl_cyc = '0, mdl_stl = '0, mdl_fls = '0;

  task automatic applyStimulus(input logic [3:0] d, input logic [3:0] e, input logic [3:0] m,
                               input logic [3:0] dm, input logic [3:0] sa, input logic [3:0] sb,
                               input logic c, input logic [3:0] ms, input logic [3:0] ws,
                               input logic r, input string tag);
    bit   lu, rt, mp, exm, exw;
    exp_t x;
    @(posedge clk);
    #1;
    D_icode = d; E_icode = e; M_icode = m; E_dstM = dm; d_srcA = sa; d_srcB = sb;
    e_cnd = c; m_stat = ms; W_stat = ws; rst = r;
    lu  = (e == 4'h5 || e == 4'hB) && dm != 4'hF && (dm == sa || dm == sb);
    rt  = (d == 4'h9) || (e == 4'h9) || (m == 4'h9);
    mp  = (e == 4'h7) && !c;
    exm = (ms != 4'h1);
    exw = (ws != 4'h1);
    if (r) begin
      mdl_mode = 0; mdl_stat = 4'h1; mdl_cyc = '0; mdl_stl = '0; mdl_fls = '0;
      x.ctrl = 7'b0011100;
    end else if (mdl_mode == 2) begin
      x.ctrl = 7'b1101110;
    end else begin
      x.ctrl = {lu | rt | (mdl_mode == 1), lu, mp | (rt & !lu), mp | lu,
                exm | exw | (mdl_mode == 1), exw, !(exm | exw) && mdl_mode == 0};
    end
    x.stat = mdl_stat;
    x.halt = (mdl_mode == 2);
    x.cyc  = mdl_cyc;
    x.stl  = mdl_stl;
    x.fls  = mdl_fls;
    x.tag  = tag;
    sb_q.push_back(x);
    if (!r) begin
      if (mdl_mode != 2) mdl_cyc++;
      if (mdl_mode == 0 && lu) mdl_stl++;
      if (mdl_mode == 0 && mp) mdl_fls++;
      if (mdl_mode != 2 && exw) begin
        mdl_mode = 2;
        mdl_stat = ws;
      end else if (mdl_mode == 0 && exm) begin
        mdl_mode = 1;
      end
    end
  endtask

  task automatic checkOutput(input exp_t x);
    logic [6:0] act;
    act = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en};
    checks++;
    if (act !== x.ctrl) begin
      errors++;
      $display("[TB] FAIL ctrl(%s): got %b expected %b (F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc_en)",
               x.tag, act, x.ctrl);
    end
    checks++;
    if (cpu_stat !== x.stat) begin
      errors++;
      $display("[TB] FAIL cpu_stat(%s): got %h expected %h", x.tag, cpu_stat, x.stat);
    end
    checks++;
    if (halted !== x.halt) begin
      errors++;
      $display("[TB] FAIL halted(%s): got %b expected %b", x.tag, halted, x.halt);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (cyc_cnt !== x.cyc || stall_cnt !== x.stl || flush_cnt !== x.fls) begin
      errors++;
      $display("[TB] FAIL counters(%s): got %0d/%0d/%0d expected %0d/%0d/%0d",
               x.tag, cyc_cnt, stall_cnt, flush_cnt, x.cyc, x.stl, x.fls);
    end
`endif
  endtask

  // Monitor: every cycle the DUT presents a full set of outputs mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      checkOutput(sb_q.pop_front());
    end
  end

  function automatic logic [3:0] rnd_icode();
    logic [3:0] pool [8];
    pool = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};
    return pool[$urandom_range(0, 7)];
  endfunction

  function automatic logic [3:0] rnd_stat(input int pct_bad);
    if ($urandom_range(0, 99) < pct_bad) return 4'($urandom_range(2, 4));
    return 4'h1;
  endfunction

  initial begin
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 1, "reset");
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 1, "reset2");
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 0, "idle");
    // Load/use, then clear.
    applyStimulus(4'h6, 4'h5, 4'h1, 4'h3, 4'h3, 4'h7, 1, 4'h1, 4'h1, 0, "lu");
    applyStimulus(4'h6, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 1, 4'h1, 4'h1, 0, "lu_clear");
    applyStimulus(4'h6, 4'hB, 4'h1, 4'h4, 4'h2, 4'h4, 1, 4'h1, 4'h1, 0, "lu_pop_srcB");
    applyStimulus(4'h6, 4'h5, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 0, "lu_none");
    // Mispredicted jump.
    applyStimulus(4'h6, 4'h7, 4'h1, 4'hF, 4'h1, 4'h2, 0, 4'h1, 4'h1, 0, "mp");
    applyStimulus(4'h6, 4'h7, 4'h1, 4'hF, 4'h1, 4'h2, 1, 4'h1, 4'h1, 0, "jxx_taken");
    // ret walking D -> E -> M.
    applyStimulus(4'h9, 4'h1, 4'h1, 4'hF, 4'h4, 4'h4, 1, 4'h1, 4'h1, 0, "ret_d");
    applyStimulus(4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 0, "ret_e");
    applyStimulus(4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 0, "ret_m");
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 0, "ret_done");
    // Load/use coinciding with ret in D.
    applyStimulus(4'h9, 4'h5, 4'h1, 4'h3, 4'h3, 4'h4, 1, 4'h1, 4'h1, 0, "lu_ret");
    // Randomized traffic without exceptions.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(rnd_icode(), rnd_icode(), rnd_icode(), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    4'h1, 4'h1, 0, "rand");
    end
    // Exception drain: ADR in M, then in W, then stopped.
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h3, 4'h1, 0, "exm");
    applyStimulus(4'h1, 4'h5, 4'h1, 4'h2, 4'h2, 4'hF, 1, 4'h1, 4'h3, 0, "drain");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(rnd_icode(), rnd_icode(), rnd_icode(), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    4'h1, 4'h1, 0, "stop");
    end
    // Reset asserted between edges while stopped.
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 1, "rst_stop");
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 0, "post_rst");
    // Direct HLT in W from running.
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h2, 0, "exw_direct");
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 0, "stop_hlt");
    applyStimulus(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 1, "rst2");
    // Randomized traffic with occasional exceptions and periodic resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(rnd_icode(), rnd_icode(), rnd_icode(), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    rnd_stat(6), rnd_stat(4), (i % 37) == 36, "rand_exc");
    end
    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
